// File: rtl/cam_pkg.sv
// Shared types for the CAM maintenance front-end: opcodes, response status,
// controller states and the EVAL-stage decision helper.
package cam_pkg;

   localparam int unsigned STAT_WIDTH = 16;

   typedef enum logic [1:0] {
      OP_INSERT = 2'd0,
      OP_DELETE = 2'd1,
      OP_SEARCH = 2'd2,
      OP_RSVD   = 2'd3
   } cam_op_e;

   typedef enum logic [1:0] {
      ST_OK        = 2'd0,
      ST_EXISTS    = 2'd1,
      ST_FULL      = 2'd2,
      ST_NOT_FOUND = 2'd3
   } cam_status_e;

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_LOOKUP = 3'd2,
      S_EVAL   = 3'd3,
      S_WRITE  = 3'd4,
      S_RESP   = 3'd5
   } cam_upd_state_e;

   typedef struct packed {
      logic        write;   // a CAM write cycle follows
      logic        alloc;   // write targets the allocator slot with valid=1
      cam_status_e status;
   } cam_eval_t;

   // Outcome of a request given the registered lookup result; reserved op behaves as SEARCH.
   function automatic cam_eval_t cam_eval(input cam_op_e op, input logic hit, input logic avail);
      cam_eval_t res;
      res.write  = 1'b0;
      res.alloc  = 1'b0;
      res.status = ST_OK;
      case (op)
         OP_INSERT: begin
            if (hit) begin
               res.status = ST_EXISTS;
            end else if (!avail) begin
               res.status = ST_FULL;
            end else begin
               res.write = 1'b1;
               res.alloc = 1'b1;
            end
         end
         OP_DELETE: begin
            if (hit) res.write = 1'b1;
            else     res.status = ST_NOT_FOUND;
         end
         default: begin
            if (!hit) res.status = ST_NOT_FOUND;
         end
      endcase
      return res;
   endfunction

endpackage

// File: rtl/cam_free_alloc.sv
// Occupancy bitmap for the CAM slots with lowest-free-slot allocation and a
// registered free-entry count.
module cam_free_alloc
   import cam_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set_en,
   input  logic                  clr_en,
   input  logic [ADDR_WIDTH-1:0] idx,
   output logic [ADDR_WIDTH-1:0] alloc_idx,
   output logic                  alloc_avail,
   output logic [ADDR_WIDTH:0]   free_count
);
   localparam int unsigned DEPTH = 2**ADDR_WIDTH;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic [DEPTH-1:0] bitmap_q;
   logic [DEPTH-1:0] bitmap_nxt;

   always_comb begin
      bitmap_nxt = bitmap_q;
      if (set_en) bitmap_nxt[idx] = 1'b1;
      if (clr_en) bitmap_nxt[idx] = 1'b0;
   end

   // free_count tracks the bitmap on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         bitmap_q   <= '0;
         free_count <= CNT_W'(DEPTH);
      end else begin
         bitmap_q   <= bitmap_nxt;
         free_count <= CNT_W'(DEPTH) - CNT_W'($countones(bitmap_nxt));
      end
   end

   // Lowest clear bit wins: scan from the top so the last hit is the lowest index
   always_comb begin
      alloc_idx   = '0;
      alloc_avail = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!bitmap_q[i]) begin
            alloc_idx   = ADDR_WIDTH'(i);
            alloc_avail = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cam_update_ctrl.sv
// Insert/delete/search front-end owning cam_core's write and lookup ports; sweeps the
// table invalid after reset. Define CAM_UPD_STATS_EN for saturating outcome counters.
module cam_update_ctrl
   import cam_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [1:0]            rsp_status,
   output logic [ADDR_WIDTH-1:0] rsp_addr,
   output logic                  cam_we,
   output logic [ADDR_WIDTH-1:0] cam_addr,
   output logic [DATA_WIDTH-1:0] cam_data,
   output logic                  cam_valid,
   output logic [DATA_WIDTH-1:0] lookup_data,
   input  logic [ADDR_WIDTH-1:0] lookup_addr,
   input  logic                  lookup_hit,
   output logic [ADDR_WIDTH:0]   free_count,
`ifdef CAM_UPD_STATS_EN
   output logic [STAT_WIDTH-1:0] stat_insert_cnt,
   output logic [STAT_WIDTH-1:0] stat_delete_cnt,
   output logic [STAT_WIDTH-1:0] stat_full_cnt,
`endif
   output logic                  init_done
);
   localparam int unsigned DEPTH = 2**ADDR_WIDTH;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   cam_upd_state_e        state_q;
   cam_upd_state_e        state_nxt;
   cam_op_e               op_q;
   logic [DATA_WIDTH-1:0] key_q;
   logic [DATA_WIDTH-1:0] key_nxt;
   logic [CNT_W-1:0]      sweep_q;
   logic                  sweep_done_c;
   logic                  accept_c;
   cam_eval_t             eval_c;
   logic [ADDR_WIDTH-1:0] eval_addr_c;
   logic [ADDR_WIDTH-1:0] alloc_idx;
   logic                  alloc_avail;
   logic                  set_en_c;
   logic                  clr_en_c;

   logic                  req_ready_d;
   logic                  rsp_valid_d;
   cam_status_e           rsp_status_d;
   logic [ADDR_WIDTH-1:0] rsp_addr_d;
   logic                  cam_we_d;
   logic [ADDR_WIDTH-1:0] cam_addr_d;
   logic [DATA_WIDTH-1:0] cam_data_d;
   logic                  cam_valid_d;
   logic [DATA_WIDTH-1:0] lookup_data_d;
   logic                  init_done_d;

   assign sweep_done_c = (sweep_q == CNT_W'(DEPTH));
   assign accept_c     = req_valid && req_ready;
   assign key_nxt      = accept_c ? req_data : key_q;
   assign eval_c       = cam_eval(op_q, lookup_hit, alloc_avail);
   assign eval_addr_c  = eval_c.alloc ? alloc_idx : (lookup_hit ? lookup_addr : '0);

   // Registered cam_addr/cam_valid identify the slot being written during WRITE
   assign set_en_c = (state_q == S_WRITE) && cam_valid;
   assign clr_en_c = (state_q == S_WRITE) && !cam_valid;

   cam_free_alloc #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_free_alloc (
      .clk         (clk),
      .reset       (reset),
      .set_en      (set_en_c),
      .clr_en      (clr_en_c),
      .idx         (cam_addr),
      .alloc_idx   (alloc_idx),
      .alloc_avail (alloc_avail),
      .free_count  (free_count)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_INIT;
      else       state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_INIT:   if (sweep_done_c) state_nxt = S_IDLE;
         S_IDLE:   if (accept_c) state_nxt = S_LOOKUP;
         S_LOOKUP: state_nxt = S_EVAL;
         S_EVAL:   state_nxt = eval_c.write ? S_WRITE : S_RESP;
         S_WRITE:  state_nxt = S_RESP;
         S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_INIT;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with state_q
   always_comb begin
      req_ready_d   = 1'b0;
      rsp_valid_d   = 1'b0;
      rsp_status_d  = cam_status_e'(rsp_status);
      rsp_addr_d    = rsp_addr;
      cam_we_d      = 1'b0;
      cam_addr_d    = '0;
      cam_data_d    = '0;
      cam_valid_d   = 1'b0;
      lookup_data_d = key_nxt;
      init_done_d   = (state_nxt != S_INIT);
      case (state_nxt)
         S_INIT: begin
            cam_we_d      = 1'b1;
            cam_addr_d    = sweep_q[ADDR_WIDTH-1:0];
            lookup_data_d = '0;
         end
         S_IDLE: req_ready_d = 1'b1;
         S_WRITE: begin
            cam_we_d    = 1'b1;
            cam_addr_d  = eval_addr_c;
            cam_data_d  = key_q;
            cam_valid_d = eval_c.alloc;
         end
         S_RESP: rsp_valid_d = 1'b1;
         default: ;
      endcase
      if (state_q == S_EVAL) begin
         rsp_status_d = eval_c.status;
         rsp_addr_d   = eval_addr_c;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q        <= OP_INSERT;
         key_q       <= '0;
         sweep_q     <= '0;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_status  <= '0;
         rsp_addr    <= '0;
         cam_we      <= 1'b0;
         cam_addr    <= '0;
         cam_data    <= '0;
         cam_valid   <= 1'b0;
         lookup_data <= '0;
         init_done   <= 1'b0;
      end else begin
         if (accept_c) op_q <= cam_op_e'(req_op);
         key_q <= key_nxt;
         if (state_q == S_INIT && !sweep_done_c) sweep_q <= sweep_q + CNT_W'(1);
         req_ready   <= req_ready_d;
         rsp_valid   <= rsp_valid_d;
         rsp_status  <= rsp_status_d;
         rsp_addr    <= rsp_addr_d;
         cam_we      <= cam_we_d;
         cam_addr    <= cam_addr_d;
         cam_data    <= cam_data_d;
         cam_valid   <= cam_valid_d;
         lookup_data <= lookup_data_d;
         init_done   <= init_done_d;
      end
   end

`ifdef CAM_UPD_STATS_EN
   logic resp_entry_c;
   assign resp_entry_c = (state_nxt == S_RESP) && (state_q != S_RESP);

   // Outcome counters bump once per response, saturating at all-ones
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_insert_cnt <= '0;
         stat_delete_cnt <= '0;
         stat_full_cnt   <= '0;
      end else if (resp_entry_c) begin
         if (op_q == OP_INSERT && rsp_status_d == ST_OK && stat_insert_cnt != '1)
            stat_insert_cnt <= stat_insert_cnt + STAT_WIDTH'(1);
         if (op_q == OP_DELETE && rsp_status_d == ST_OK && stat_delete_cnt != '1)
            stat_delete_cnt <= stat_delete_cnt + STAT_WIDTH'(1);
         if (rsp_status_d == ST_FULL && stat_full_cnt != '1)
            stat_full_cnt <= stat_full_cnt + STAT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_cam_update_ctrl.sv
// Bench for cam_update_ctrl: a registered cam_core stand-in plus a slot-table
// reference model driven by directed and random insert/delete/search traffic.
module tb_cam_update_ctrl;
   import cam_pkg::*;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [DW-1:0] req_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_status;
   logic [AW-1:0] rsp_addr;
   logic          cam_we;
   logic [AW-1:0] cam_addr;
   logic [DW-1:0] cam_data;
   logic          cam_valid;
   logic [DW-1:0] lookup_data;
   logic [AW-1:0] lookup_addr;
   logic          lookup_hit;
   logic [AW:0]   free_count;
   logic          init_done;

   int n_tests;
   int n_fail;

   always #5 clk = ~clk;

   cam_update_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_data    (req_data),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_status  (rsp_status),
      .rsp_addr    (rsp_addr),
      .cam_we      (cam_we),
      .cam_addr    (cam_addr),
      .cam_data    (cam_data),
      .cam_valid   (cam_valid),
      .lookup_data (lookup_data),
      .lookup_addr (lookup_addr),
      .lookup_hit  (lookup_hit),
      .free_count  (free_count),
      .init_done   (init_done)
   );

   // cam_core stand-in: unreset table, lookup result registered one cycle after lookup_data
   logic [DW-1:0] cam_key [DEPTH];
   logic          cam_vld [DEPTH];
   logic          scramble;
   int unsigned   we_total = 0;
   logic [AW-1:0] we_addr;
   logic          we_valid;
   logic [DW-1:0] we_data;

   always @(posedge clk) begin : cam_model
      logic          h;
      logic [AW-1:0] a;
      h = 1'b0;
      a = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (cam_vld[i] === 1'b1 && cam_key[i] === lookup_data && !h) begin
            h = 1'b1;
            a = AW'(i);
         end
      end
      lookup_hit  <= h;
      lookup_addr <= a;
      if (scramble) begin
         for (int i = 0; i < DEPTH; i++) begin
            cam_key[i] <= $urandom;
            cam_vld[i] <= 1'b1;
         end
      end else if (cam_we) begin
         cam_key[cam_addr] <= cam_data;
         cam_vld[cam_addr] <= cam_valid;
         we_total          <= we_total + 1;
         we_addr           <= cam_addr;
         we_valid          <= cam_valid;
         we_data           <= cam_data;
      end
   end

   // Reference model: which slot holds which key
   logic [DW-1:0] ref_key  [DEPTH];
   logic          ref_used [DEPTH];

   function automatic int ref_free();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (!ref_used[i]) n++;
      return n;
   endfunction

   task automatic ref_apply(input logic [1:0] op, input logic [DW-1:0] k,
                            output logic [1:0] st, output logic [AW-1:0] ad, output logic wr);
      int hit_i = -1;
      int free_i = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (ref_used[i] && ref_key[i] == k && hit_i < 0) hit_i = i;
         if (!ref_used[i] && free_i < 0) free_i = i;
      end
      wr = 1'b0;
      ad = '0;
      if (op == 2'd0) begin
         if (hit_i >= 0) begin
            st = ST_EXISTS;
            ad = AW'(hit_i);
         end else if (free_i < 0) begin
            st = ST_FULL;
         end else begin
            st = ST_OK;
            ad = AW'(free_i);
            wr = 1'b1;
            ref_used[free_i] = 1'b1;
            ref_key[free_i]  = k;
         end
      end else if (op == 2'd1) begin
         if (hit_i >= 0) begin
            st = ST_OK;
            ad = AW'(hit_i);
            wr = 1'b1;
            ref_used[hit_i] = 1'b0;
         end else begin
            st = ST_NOT_FOUND;
         end
      end else begin
         if (hit_i >= 0) begin
            st = ST_OK;
            ad = AW'(hit_i);
         end else begin
            st = ST_NOT_FOUND;
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input int cyc);
      reset     = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      repeat (cyc) @(negedge clk);
      check("rst_out", 64'({req_ready, rsp_valid, cam_we, init_done, cam_valid}), 64'(0));
      check("rst_free", 64'(free_count), 64'(DEPTH));
      check("rst_lookup", 64'(lookup_data), 64'(0));
      scramble = 1'b0;
      reset    = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_used[i] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         check("sweep", 64'({cam_we, cam_valid, req_ready, rsp_valid, init_done, cam_addr, cam_data}),
               64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, AW'(i), DW'(0)}));
      end
      @(negedge clk);
      check("init_done", 64'({init_done, req_ready, cam_we, rsp_valid}), 64'(4'b1100));
      check("init_free", 64'(free_count), 64'(DEPTH));
   endtask

   task automatic do_req(input string tag, input logic [1:0] op, input logic [DW-1:0] k, input int hold);
      logic [1:0]    est;
      logic [AW-1:0] ead;
      logic          ewr;
      int unsigned   we0;
      int            cyc = 0;
      int            waited = 0;
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_ready"}, 64'(req_ready), 64'(1));
      ref_apply(op, k, est, ead, ewr);
      we0       = we_total;
      req_valid = 1'b1;
      req_op    = op;
      req_data  = k;
      @(posedge clk);
      do begin
         @(negedge clk);
         req_valid = 1'b0;
         cyc++;
      end while (!rsp_valid && cyc < 20);
      check({tag, "_lat"}, 64'(cyc), 64'(ewr ? 4 : 3));
      check({tag, "_status"}, 64'(rsp_status), 64'(est));
      check({tag, "_addr"}, 64'(rsp_addr), 64'(ead));
      check({tag, "_free"}, 64'(free_count), 64'(ref_free()));
      check({tag, "_we"}, 64'(we_total - we0), 64'(ewr));
      check({tag, "_lkdata"}, 64'(lookup_data), 64'(k));
      if (ewr)
         check({tag, "_wr"}, 64'({we_addr, we_valid, we_data}), 64'({ead, op == 2'd0, k}));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold"}, 64'({rsp_valid, req_ready, rsp_status, rsp_addr}),
               64'({1'b1, 1'b0, est, ead}));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_done"}, 64'({rsp_valid, req_ready}), 64'(2'b01));
   endtask

   initial begin : stim
      logic [DW-1:0] pool [6];
      n_tests   = 0;
      n_fail    = 0;
      reset     = 1'b1;
      scramble  = 1'b1;
      req_valid = 1'b0;
      req_op    = '0;
      req_data  = '0;
      rsp_ready = 1'b0;

      do_reset(2);

      do_req("ins_first", 2'd0, 32'hDEAD_BEEF, 0);
      do_req("srch_first", 2'd2, 32'hDEAD_BEEF, 0);
      do_req("ins_dup", 2'd0, 32'hDEAD_BEEF, 0);
      for (int i = 1; i < DEPTH; i++)
         do_req("fill", 2'd0, DW'(32'h1000_0000 + (i << 16) + $urandom_range(0, 16'hFFFF)), 0);
      do_req("ins_full", 2'd0, 32'h2000_0001, 0);
      do_req("del_7", 2'd1, ref_key[7], 0);
      do_req("ins_7", 2'd0, 32'h2000_0002, 0);
      do_req("del_absent", 2'd1, 32'h3000_0003, 5);

      pool[0] = 32'hDEAD_BEEF;
      pool[1] = ref_key[5];
      pool[2] = ref_key[19];
      pool[3] = 32'h0BAD_0001;
      pool[4] = 32'h0BAD_0002;
      pool[5] = 32'h0BAD_0003;
      for (int n = 0; n < 40; n++)
         do_req("rnd", 2'($urandom_range(0, 3)), pool[$urandom_range(0, 5)], int'($urandom_range(0, 2)));

      if (ref_free() == 0) do_req("del_room", 2'd1, ref_key[0], 0);

      // Reset lands while the insert's WRITE cycle is on the bus
      req_valid = 1'b1;
      req_op    = 2'd0;
      req_data  = 32'hCAFE_F00D;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("wr_active", 64'({cam_we, cam_valid, rsp_valid}), 64'(3'b110));
      do_reset(1);
      do_req("srch_lost", 2'd2, 32'hCAFE_F00D, 0);
      do_req("srch_dead", 2'd2, 32'hDEAD_BEEF, 0);
      do_req("ins_again", 2'd0, 32'h0BAD_0001, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cam_update_ctrl.md
Name: cam_update_ctrl

Overview:
Maintenance front-end that sits directly upstream of cam_core and owns its write port and lookup port.
- Accepts insert/delete/search requests over a valid/ready handshake.
- Performs a lookup through the CAM, allocates the lowest free slot on insert, and invalidates the matching slot on delete.
- Returns a status response.
- After reset, sweeps every CAM entry to invalid, because the CAM table itself has no reset.

Parameters:
DATA_WIDTH, 32, key width; matches cam_core.
ADDR_WIDTH, 5, CAM index width; depth = 2**ADDR_WIDTH.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_op  in  2  cam_op_e: 0 INSERT, 1 DELETE, 2 SEARCH, 3 reserved (treated as SEARCH)
req_data  in  DATA_WIDTH  key
rsp_valid  out  1  response valid; held until rsp_ready
rsp_ready  in  1  response accept
rsp_status  out  2  cam_status_e: 0 OK, 1 EXISTS, 2 FULL, 3 NOT_FOUND
rsp_addr  out  ADDR_WIDTH  affected/matching index
cam_we  out  1  to cam_core
cam_addr  out  ADDR_WIDTH  to cam_core
cam_data  out  DATA_WIDTH  to cam_core
cam_valid  out  1  to cam_core
lookup_data  out  DATA_WIDTH  to cam_core
lookup_addr  in  ADDR_WIDTH  from cam_core; registered, 1 cycle after lookup_data
lookup_hit  in  1  from cam_core; registered, 1 cycle after lookup_data
free_count  out  ADDR_WIDTH+1  number of unoccupied entries
init_done  out  1  high once the init sweep completes

Behaviour:
- Reset values: state=INIT, sweep counter=0, occupancy bitmap=0, all outputs 0 except free_count=2**ADDR_WIDTH.
- INIT state:
  - Drives cam_we=1, cam_valid=0, cam_data=0, cam_addr=counter, for 2**ADDR_WIDTH cycles.
  - After the last address: init_done=1 and state moves to IDLE.
  - req_ready=0 throughout.
- A reset asserted in any state restarts INIT; any in-flight request is dropped with no response.
- IDLE: req_ready=1. On req_valid&&req_ready, capture op and data, then go to LOOKUP.
- LOOKUP, one cycle: lookup_data = captured key. Go to EVAL.
  - lookup_data holds the captured key in every non-INIT state and 0 in INIT.
- EVAL: sample lookup_hit/lookup_addr, then:
  - INSERT, hit: status EXISTS, rsp_addr=lookup_addr, no write.
  - INSERT, miss, free_count==0: status FULL, rsp_addr=0, no write.
  - INSERT, miss, free available: WRITE at alloc index (lowest clear bitmap bit), cam_valid=1, set bitmap bit; status OK, rsp_addr=index.
  - DELETE, hit: WRITE at lookup_addr, cam_valid=0, cam_data=key, clear bitmap bit; status OK.
  - DELETE, miss: status NOT_FOUND, rsp_addr=0.
  - SEARCH: status OK (hit) or NOT_FOUND (miss); rsp_addr=lookup_addr on hit, else 0.
- WRITE, one cycle: cam_we=1. The bitmap updates on the same edge.
- RESP: rsp_valid=1 until rsp_ready, then return to IDLE.
  - rsp_status/rsp_addr are stable while rsp_valid is high.
- Latency: accept edge to first rsp_valid cycle is 3 cycles without a write, 4 cycles with a write.
- cam_we is never high outside INIT and WRITE.
- The insert-time duplicate check guarantees at most one hit. This preserves the one-hot requirement of the CAM's address encoder.
- free_count = 2**ADDR_WIDTH minus popcount(bitmap), updated on the same edge as the bitmap.

Optional Feature:
CAM_UPD_STATS_EN:
- Defined: adds outputs stat_insert_cnt[15:0], stat_delete_cnt[15:0], stat_full_cnt[15:0].
  - Each counter saturates at 16'hFFFF.
  - Each increments on entry to RESP with the respective successful INSERT, successful DELETE, or FULL outcome.
  - All counters clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cam_pkg: cam_op_e, cam_status_e, cam_upd_state_e (INIT, IDLE, LOOKUP, EVAL, WRITE, RESP), STAT_WIDTH=16.
- Sub-module cam_free_alloc holds:
  - the occupancy bitmap, with set/clear ports;
  - a lowest-zero priority encoder (alloc_idx, alloc_avail);
  - free_count.

Test Plan:
- Reset with ADDR_WIDTH=5 -> 32 consecutive cycles of cam_we=1, cam_valid=0, cam_addr 0..31; then init_done=1, req_ready=1, free_count=32.
- INSERT 32'hDEAD_BEEF -> rsp OK, addr 0, free_count=31; SEARCH same key -> OK, addr 0, no cam_we.
- INSERT 32'hDEAD_BEEF again -> EXISTS, addr 0, no cam_we, free_count unchanged.
- Fill all 32 slots, then INSERT a new key -> FULL, addr 0, no cam_we. DELETE the key at addr 7 -> OK, addr 7, free_count=1. Next INSERT -> OK, addr 7.
- DELETE an absent key -> NOT_FOUND; hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_status remain stable and req_ready stays 0.
- Assert reset in the cycle WRITE is active -> no response; INIT restarts at cam_addr 0; free_count=32.
